// File: rtl/pad_bank_power_sequencer.sv
// Bank power sequencer: sleep/deep-sleep entry, then VDD settle, isolation release and grouped pad enable on wake.
// Define PAD_RETENTION_EN to hold pad_out through low-power states via an RTN_LEVEL-qualified retention register.
module pad_bank_power_sequencer #(
    parameter int NUM_PADS          = 8,
    parameter int GROUP_SIZE        = 2,
    parameter int LIGHT_WAKE_CYCLES = 2,
    parameter int DEEP_WAKE_CYCLES  = 8,
    parameter int STAGGER_CYCLES    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sleep_req,
    input  logic                deep_sleep_req,
    input  logic                wakeup_req,
    input  logic [NUM_PADS-1:0] cfg_ds,
    input  logic [NUM_PADS-1:0] oe_mask,
    input  logic [NUM_PADS-1:0] A,
    output logic [2:0]          power_state,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] IE,
    output logic [NUM_PADS-1:0] OE,
    output logic [NUM_PADS-1:0] DS,
    output logic                VDD_ON,
    output logic                ISO_EN,
    output logic                RTN_LEVEL,
    output logic                LSBIAS,
    output logic                wake_done
);
    localparam int G             = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int STAGGER_TOTAL = G * STAGGER_CYCLES;
    localparam int CNT_MAX       = (DEEP_WAKE_CYCLES > STAGGER_TOTAL) ? DEEP_WAKE_CYCLES : STAGGER_TOTAL;
    localparam int CW            = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_ACTIVE   = 3'd0,
        ST_SLEEP    = 3'd1,
        ST_DEEP     = 3'd2,
        ST_WAKE_PWR = 3'd3,
        ST_WAKE_EN  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_PADS-1:0] ie_q, ie_d, oe_q, oe_d, ds_q, ds_d, pad_q, pad_d;
    logic                vdd_q, vdd_d, iso_q, iso_d, rtn_q, rtn_d, lsb_q, lsb_d, done_q, done_d;
    logic [NUM_PADS-1:0] hold_val, en_mask;
    logic                go_deep, go_sleep;

`ifdef PAD_RETENTION_EN
    logic [NUM_PADS-1:0] ret_q;
    // Retention register freezes while RTN_LEVEL is asserted, so deep sleep restores from it.
    assign hold_val = rtn_q ? ret_q : pad_q;
    always_ff @(posedge clk) begin
        if (rst) ret_q <= '0;
        else if (!rtn_q) ret_q <= pad_d;
    end
`else
    assign hold_val = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ie_d     = ie_q;
        oe_d     = oe_q;
        ds_d     = ds_q;
        pad_d    = hold_val;
        vdd_d    = vdd_q;
        iso_d    = iso_q;
        rtn_d    = rtn_q;
        lsb_d    = lsb_q;
        done_d   = 1'b0;
        go_deep  = 1'b0;
        go_sleep = 1'b0;
        en_mask  = '0;
        unique case (state_q)
            ST_ACTIVE: begin
                if (deep_sleep_req)   go_deep  = 1'b1;
                else if (sleep_req)   go_sleep = 1'b1;
                else begin
                    ie_d  = '1;
                    oe_d  = oe_mask;
                    ds_d  = cfg_ds & oe_mask;
                    pad_d = A & oe_mask;
                end
            end
            ST_SLEEP: begin
                if (deep_sleep_req) go_deep = 1'b1;
                else if (!sleep_req && wakeup_req) begin
                    state_d = ST_WAKE_PWR;
                    cnt_d   = CW'(LIGHT_WAKE_CYCLES);
                    vdd_d   = 1'b1;
                end
            end
            ST_DEEP: begin
                if (!deep_sleep_req && wakeup_req) begin
                    state_d = ST_WAKE_PWR;
                    cnt_d   = CW'(DEEP_WAKE_CYCLES);
                    vdd_d   = 1'b1;
                end
            end
            ST_WAKE_PWR: begin
                if (deep_sleep_req)          go_deep  = 1'b1;
                else if (sleep_req)          go_sleep = 1'b1;
                else if (cnt_q <= CW'(1)) begin
                    state_d = ST_WAKE_EN;
                    cnt_d   = '0;
                    iso_d   = 1'b0;
                    rtn_d   = 1'b0;
                    lsb_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAKE_EN: begin
                if (deep_sleep_req)   go_deep  = 1'b1;
                else if (sleep_req)   go_sleep = 1'b1;
                else begin
                    // cnt_q counts edges since entering WAKE_EN; group k opens once it reaches k*STAGGER_CYCLES.
                    for (int i = 0; i < NUM_PADS; i++)
                        en_mask[i] = int'(cnt_q) >= (i / GROUP_SIZE) * STAGGER_CYCLES;
                    if (int'(cnt_q) >= STAGGER_TOTAL - 1) begin
                        en_mask = '1;
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else if (int'(cnt_q) < CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    ie_d  = en_mask;
                    oe_d  = oe_mask & en_mask;
                    ds_d  = cfg_ds & oe_mask & en_mask;
                    pad_d = (A & oe_mask & en_mask) | (hold_val & ~en_mask);
                end
            end
            default: state_d = ST_ACTIVE;
        endcase

        if (go_deep) begin
            state_d = ST_DEEP;
            cnt_d   = '0;
            ie_d    = '0;
            oe_d    = '0;
            ds_d    = '0;
            vdd_d   = 1'b0;
            iso_d   = 1'b1;
            rtn_d   = 1'b1;
            lsb_d   = 1'b1;
        end else if (go_sleep) begin
            state_d = ST_SLEEP;
            cnt_d   = '0;
            ie_d    = '0;
            oe_d    = '0;
            ds_d    = '0;
            vdd_d   = 1'b1;
            iso_d   = 1'b1;
            rtn_d   = 1'b0;
            lsb_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            ie_q    <= '1;
            oe_q    <= '0;
            ds_q    <= '0;
            pad_q   <= '0;
            vdd_q   <= 1'b1;
            iso_q   <= 1'b0;
            rtn_q   <= 1'b0;
            lsb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ie_q    <= ie_d;
            oe_q    <= oe_d;
            ds_q    <= ds_d;
            pad_q   <= pad_d;
            vdd_q   <= vdd_d;
            iso_q   <= iso_d;
            rtn_q   <= rtn_d;
            lsb_q   <= lsb_d;
            done_q  <= done_d;
        end
    end

    assign power_state = state_q;
    assign pad_out     = pad_q;
    assign IE          = ie_q;
    assign OE          = oe_q;
    assign DS          = ds_q;
    assign VDD_ON      = vdd_q;
    assign ISO_EN      = iso_q;
    assign RTN_LEVEL   = rtn_q;
    assign LSBIAS      = lsb_q;
    assign wake_done   = done_q;
endmodule

// File: tb/tb_pad_bank_power_sequencer.sv
// Directed bench for pad_bank_power_sequencer: 8-pad default instance plus a 5-pad instance sharing the controls.
module tb_pad_bank_power_sequencer;
`ifdef PAD_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    logic       clk, rst, sleep_req, deep_sleep_req, wakeup_req;
    logic [7:0] cfg_ds, oe_mask, A;
    logic [2:0] power_state, power_state5;
    logic [7:0] pad_out, IE, OE, DS;
    logic [4:0] pad_out5, IE5, OE5, DS5;
    logic       VDD_ON, ISO_EN, RTN_LEVEL, LSBIAS, wake_done;
    logic       VDD_ON5, ISO_EN5, RTN_LEVEL5, LSBIAS5, wake_done5;
    int         tests = 0;
    int         fails = 0;

    pad_bank_power_sequencer dut (
        .clk(clk), .rst(rst), .sleep_req(sleep_req), .deep_sleep_req(deep_sleep_req),
        .wakeup_req(wakeup_req), .cfg_ds(cfg_ds), .oe_mask(oe_mask), .A(A),
        .power_state(power_state), .pad_out(pad_out), .IE(IE), .OE(OE), .DS(DS),
        .VDD_ON(VDD_ON), .ISO_EN(ISO_EN), .RTN_LEVEL(RTN_LEVEL), .LSBIAS(LSBIAS),
        .wake_done(wake_done)
    );

    pad_bank_power_sequencer #(.NUM_PADS(5), .GROUP_SIZE(2)) dut5 (
        .clk(clk), .rst(rst), .sleep_req(sleep_req), .deep_sleep_req(deep_sleep_req),
        .wakeup_req(wakeup_req), .cfg_ds(cfg_ds[4:0]), .oe_mask(oe_mask[4:0]), .A(A[4:0]),
        .power_state(power_state5), .pad_out(pad_out5), .IE(IE5), .OE(OE5), .DS(DS5),
        .VDD_ON(VDD_ON5), .ISO_EN(ISO_EN5), .RTN_LEVEL(RTN_LEVEL5), .LSBIAS(LSBIAS5),
        .wake_done(wake_done5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sleep_req = 1'b0; deep_sleep_req = 1'b0; wakeup_req = 1'b0;
        cfg_ds = 8'h00; oe_mask = 8'h00; A = 8'h00;
        tick(); tick();
        chk("rst_state", power_state, 0);
        chk("rst_vdd", VDD_ON, 1);
        chk("rst_iso", ISO_EN, 0);
        chk("rst_rtn", RTN_LEVEL, 0);
        chk("rst_lsb", LSBIAS, 0);
        chk("rst_ie", IE, 8'hFF);
        chk("rst_oe", OE, 0);
        chk("rst_ds", DS, 0);
        chk("rst_pad", pad_out, 0);
        chk("rst_done", wake_done, 0);
        chk("rst_ie5", IE5, 5'h1F);

        rst = 1'b0; oe_mask = 8'h0F; A = 8'hFF; cfg_ds = 8'hFF;
        tick();
        chk("act_pad", pad_out, 8'h0F);
        chk("act_oe", OE, 8'h0F);
        chk("act_ds", DS, 8'h0F);
        chk("act_ie", IE, 8'hFF);

        A = 8'hA5; oe_mask = 8'hFF;
        tick();
        chk("act_pad_a5", pad_out, 8'hA5);
        chk("act_oe_ff", OE, 8'hFF);

        sleep_req = 1'b1; tick(); sleep_req = 1'b0;
        chk("slp_state", power_state, 1);
        chk("slp_iso", ISO_EN, 1);
        chk("slp_vdd", VDD_ON, 1);
        chk("slp_lsb", LSBIAS, 1);
        chk("slp_rtn", RTN_LEVEL, 0);
        chk("slp_ie", IE, 0);
        chk("slp_oe", OE, 0);
        chk("slp_ds", DS, 0);
        chk("slp_pad", pad_out, RET ? 8'hA5 : 8'h00);
        tick();
        chk("slp_hold_state", power_state, 1);
        chk("slp_hold_pad", pad_out, RET ? 8'hA5 : 8'h00);

        wakeup_req = 1'b1; tick(); wakeup_req = 1'b0;
        chk("lw_e0_state", power_state, 3);
        chk("lw_e0_iso", ISO_EN, 1);
        chk("lw_e0_vdd", VDD_ON, 1);
        tick();
        chk("lw_e1_state", power_state, 3);
        chk("lw_e1_ie", IE, 0);
        tick();
        chk("lw_e2_state", power_state, 4);
        chk("lw_e2_iso", ISO_EN, 0);
        chk("lw_e2_lsb", LSBIAS, 0);
        chk("lw_e2_ie", IE, 0);
        tick();
        chk("lw_e3_ie", IE, 8'h03);
        chk("lw_e3_oe", OE, 8'h03);
        chk("lw_e3_ds", DS, 8'h03);
        chk("lw_e3_pad", pad_out, RET ? 8'hA5 : 8'h01);
        chk("lw_e3_state", power_state, 4);
        chk("lw_e3_ie5", IE5, 5'h03);
        tick();
        chk("lw_e4_ie", IE, 8'h0F);
        chk("lw_e4_pad", pad_out, RET ? 8'hA5 : 8'h05);
        chk("lw_e4_ie5", IE5, 5'h0F);
        chk("lw_e4_state5", power_state5, 4);
        tick();
        chk("lw_e5_ie", IE, 8'h3F);
        chk("lw_e5_pad", pad_out, RET ? 8'hA5 : 8'h25);
        chk("lw_e5_state", power_state, 4);
        chk("lw_e5_done", wake_done, 0);
        chk("lw_e5_ie5", IE5, 5'h1F);
        chk("lw_e5_state5", power_state5, 0);
        chk("lw_e5_done5", wake_done5, 1);
        tick();
        chk("lw_e6_ie", IE, 8'hFF);
        chk("lw_e6_state", power_state, 0);
        chk("lw_e6_done", wake_done, 1);
        chk("lw_e6_pad", pad_out, 8'hA5);
        chk("lw_e6_ds", DS, 8'hFF);
        chk("lw_e6_done5", wake_done5, 0);
        tick();
        chk("lw_e7_done", wake_done, 0);
        chk("lw_e7_state", power_state, 0);

        deep_sleep_req = 1'b1; tick(); deep_sleep_req = 1'b0;
        chk("dp_state", power_state, 2);
        chk("dp_vdd", VDD_ON, 0);
        chk("dp_rtn", RTN_LEVEL, 1);
        chk("dp_iso", ISO_EN, 1);
        chk("dp_lsb", LSBIAS, 1);
        chk("dp_ie", IE, 0);
        chk("dp_pad", pad_out, RET ? 8'hA5 : 8'h00);
        sleep_req = 1'b1; tick(); sleep_req = 1'b0;
        chk("dp_ignore_sleep", power_state, 2);

        wakeup_req = 1'b1; tick(); wakeup_req = 1'b0;
        chk("dw_e0_state", power_state, 3);
        chk("dw_e0_vdd", VDD_ON, 1);
        chk("dw_e0_rtn", RTN_LEVEL, 1);
        chk("dw_e0_iso", ISO_EN, 1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("dw_e%0d_state", i), power_state, 3);
        end
        chk("dw_e7_iso", ISO_EN, 1);
        tick();
        chk("dw_e8_state", power_state, 4);
        chk("dw_e8_iso", ISO_EN, 0);
        chk("dw_e8_rtn", RTN_LEVEL, 0);
        for (int i = 9; i <= 11; i++) begin
            tick();
            chk($sformatf("dw_e%0d_state", i), power_state, 4);
            chk($sformatf("dw_e%0d_done", i), wake_done, 0);
        end
        tick();
        chk("dw_e12_state", power_state, 0);
        chk("dw_e12_done", wake_done, 1);
        chk("dw_e12_ie", IE, 8'hFF);
        tick();
        chk("dw_e13_done", wake_done, 0);

        sleep_req = 1'b1; deep_sleep_req = 1'b1; tick();
        sleep_req = 1'b0; deep_sleep_req = 1'b0;
        chk("both_state", power_state, 2);
        chk("both_vdd", VDD_ON, 0);
        chk("both_rtn", RTN_LEVEL, 1);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_state", power_state, 0);
        chk("mid_rst_vdd", VDD_ON, 1);
        chk("mid_rst_iso", ISO_EN, 0);
        chk("mid_rst_rtn", RTN_LEVEL, 0);
        chk("mid_rst_lsb", LSBIAS, 0);
        chk("mid_rst_ie", IE, 8'hFF);
        chk("mid_rst_oe", OE, 0);
        chk("mid_rst_pad", pad_out, 0);

        tick();
        sleep_req = 1'b1; tick(); sleep_req = 1'b0;
        wakeup_req = 1'b1; tick(); wakeup_req = 1'b0;
        tick(); tick(); tick();
        chk("ab_e3_ie", IE, 8'h03);
        chk("ab_e3_state", power_state, 4);
        deep_sleep_req = 1'b1; tick(); deep_sleep_req = 1'b0;
        chk("ab_e4_state", power_state, 2);
        chk("ab_e4_ie", IE, 0);
        chk("ab_e4_done", wake_done, 0);
        chk("ab_e4_vdd", VDD_ON, 0);
        chk("ab_e4_state5", power_state5, 2);
        tick();
        chk("ab_e5_done", wake_done, 0);
        chk("ab_e5_state", power_state, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
